cbdb_tick_gen: RTL and testbench

CBDB_TICK_GEN -- requirements
Module: cbdb_tick_gen

---
 rtl/cbdb_tick_gen.sv | 89 ++++++++
 tb/tb_cbdb_tick_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbdb_tick_gen.sv
// rtl/cbdb_tick_gen.sv - prescaled tick generator feeding a downstream down-counter
// Issues one TICK every DIVR enabled cycles; one-shot mode halts on TCI from the downstream counter.
module cbdb_tick_gen #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CDN,
    input  logic         EN,
    input  logic         START,
    input  logic         STOP,
    input  logic         MODE,
    input  logic         LD,
    input  logic [W-1:0] DIV,
    input  logic         TCI,
    output logic         TICK,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] pc;
    logic [W-1:0] pc_nxt;
    logic [W-1:0] divr;
    logic [W-1:0] eff_div;
    logic         err_q;
    logic         err_nxt;
    logic         pc_zero;

    // A same-cycle LD overrides the stored divide value for the start decision
    assign eff_div = LD ? DIV : divr;
    assign pc_zero = (pc == '0);

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            state <= IDLE;
            pc    <= '0;
            divr  <= ONE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            err_q <= err_nxt;
            if (LD) begin
                divr <= DIV;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        err_nxt   = 1'b0;
        if (STOP) begin
            state_nxt = IDLE;
            pc_nxt    = '0;
        end else if (state != RUN && START) begin
            if (eff_div != '0) begin
                state_nxt = RUN;
                pc_nxt    = eff_div - ONE;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (state == RUN && EN) begin
            // Reload uses the stored DIVR, so a mid-run LD only shapes later periods
            pc_nxt = pc_zero ? (divr - ONE) : (pc - ONE);
            if (MODE && pc_zero && TCI) begin
                state_nxt = HALT;
            end
        end
    end

    always_comb begin
        TICK = (state == RUN) && EN && pc_zero;
        BUSY = (state == RUN);
        DONE = (state == HALT);
        ERR  = err_q;
    end

endmodule

// File: tb/tb_cbdb_tick_gen.sv
// tb/tb_cbdb_tick_gen.sv - directed scoreboard bench for cbdb_tick_gen
// Expected tick cycles are queued when a run is started and popped as cycles elapse.
module tb_cbdb_tick_gen;

    logic       CLK = 1'b0;
    logic       CDN;
    logic       EN;
    logic       START;
    logic       STOP;
    logic       MODE;
    logic       LD;
    logic [7:0] DIV;
    logic       TCI;
    logic       TICK;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int         total = 0;
    int         bad   = 0;
    int         tcnt  = 0;
    int         s     = 0;
    int         exp_q[$];
    logic [3:0] dcnt;
    logic       dload;

    cbdb_tick_gen #(.W(8)) dut (
        .CLK   (CLK),
        .CDN   (CDN),
        .EN    (EN),
        .START (START),
        .STOP  (STOP),
        .MODE  (MODE),
        .LD    (LD),
        .DIV   (DIV),
        .TCI   (TCI),
        .TICK  (TICK),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    // Downstream 4-bit down-counter: CAI = TICK, CAO = count at zero
    always @(posedge CLK) begin
        if (dload) begin
            dcnt <= 4'd3;
        end else if (TICK) begin
            dcnt <= dcnt - 4'd1;
        end
    end
    assign TCI = (dcnt == 4'd0);

    initial begin
        #300000;
        $display("FAIL timeout tcnt=%0d", tcnt);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic obs, input logic ex);
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, tcnt, obs, ex);
        end
    endtask

    task automatic step();
        logic ex;
        @(posedge CLK);
        tcnt++;
        @(negedge CLK);
        ex = 1'b0;
        if (exp_q.size() > 0 && exp_q[0] == tcnt) begin
            ex = 1'b1;
            void'(exp_q.pop_front());
        end
        chk("tick", TICK, ex);
    endtask

    initial begin
        CDN   = 1'b1;
        EN    = 1'b1;
        START = 1'b0;
        STOP  = 1'b0;
        MODE  = 1'b0;
        LD    = 1'b0;
        DIV   = 8'd0;
        dload = 1'b1;
        #1 CDN = 1'b0;
        #1;
        chk("rst_tick", TICK, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_err",  ERR,  1'b0);
        step();
        step();
        CDN   = 1'b1;
        dload = 1'b0;
        step();

        // Continuous, DIV=4: ticks 4, 8, 12 cycles after start
        LD = 1'b1; DIV = 8'd4; START = 1'b1;
        s = tcnt + 1;
        exp_q.push_back(s + 3); exp_q.push_back(s + 7); exp_q.push_back(s + 11);
        step();
        LD = 1'b0; START = 1'b0;
        chk("busy_a", BUSY, 1'b1);
        repeat (12) begin
            step();
            chk("busy_a", BUSY, 1'b1);
        end
        STOP = 1'b1; step(); STOP = 1'b0;
        chk("stop_a", BUSY, 1'b0);
        chk("q_a", exp_q.size() == 0, 1'b1);

        // DIV=3 with EN low for two edges mid-period
        LD = 1'b1; DIV = 8'd3; START = 1'b1;
        s = tcnt + 1;
        exp_q.push_back(s + 2); exp_q.push_back(s + 5);
        exp_q.push_back(s + 10); exp_q.push_back(s + 13);
        step();
        LD = 1'b0; START = 1'b0;
        repeat (14) begin
            EN = !(tcnt == s + 6 || tcnt == s + 7);
            step();
        end
        EN = 1'b1;
        STOP = 1'b1; step(); STOP = 1'b0;
        chk("q_b", exp_q.size() == 0, 1'b1);

        // One-shot, DIV=2, downstream counter loaded with 3
        MODE = 1'b1; LD = 1'b1; DIV = 8'd2; START = 1'b1; dload = 1'b1;
        s = tcnt + 1;
        exp_q.push_back(s + 1); exp_q.push_back(s + 3);
        exp_q.push_back(s + 5); exp_q.push_back(s + 7);
        step();
        LD = 1'b0; START = 1'b0; dload = 1'b0;
        repeat (7) step();
        chk("tci_4th", TCI, 1'b1);
        step();
        chk("done_c", DONE, 1'b1);
        chk("busy_c", BUSY, 1'b0);
        repeat (3) begin
            step();
            chk("done_hold", DONE, 1'b1);
        end
        MODE = 1'b0; START = 1'b1;
        s = tcnt + 1;
        exp_q.push_back(s + 1);
        step();
        START = 1'b0;
        chk("halt_restart_busy", BUSY, 1'b1);
        chk("halt_restart_done", DONE, 1'b0);
        step();
        STOP = 1'b1; step(); STOP = 1'b0;
        chk("stop_c", BUSY, 1'b0);
        chk("q_c", exp_q.size() == 0, 1'b1);

        // Zero divide rejected; START with STOP stays idle
        LD = 1'b1; DIV = 8'd0; step(); LD = 1'b0;
        START = 1'b1; step(); START = 1'b0;
        chk("err_pulse", ERR, 1'b1);
        chk("err_busy", BUSY, 1'b0);
        step();
        chk("err_once", ERR, 1'b0);
        chk("err_busy2", BUSY, 1'b0);
        LD = 1'b1; DIV = 8'd3; START = 1'b1; STOP = 1'b1;
        step();
        LD = 1'b0; START = 1'b0; STOP = 1'b0;
        chk("startstop_busy", BUSY, 1'b0);
        chk("startstop_err", ERR, 1'b0);
        step();
        chk("startstop_idle", BUSY, 1'b0);

        // LD DIV=5 while running at 2: current period ends at 2, then periods of 5
        LD = 1'b1; DIV = 8'd2; START = 1'b1;
        s = tcnt + 1;
        exp_q.push_back(s + 1); exp_q.push_back(s + 3);
        exp_q.push_back(s + 8); exp_q.push_back(s + 13);
        step();
        LD = 1'b0; START = 1'b0;
        repeat (14) begin
            if (tcnt == s + 2) begin
                LD = 1'b1; DIV = 8'd5;
            end else begin
                LD = 1'b0;
            end
            step();
        end
        LD = 1'b0;
        STOP = 1'b1; step(); STOP = 1'b0;
        chk("q_e", exp_q.size() == 0, 1'b1);

        // Reset mid-run during a tick, then restart with default DIVR=1
        LD = 1'b1; DIV = 8'd3; START = 1'b1;
        s = tcnt + 1;
        exp_q.push_back(s + 2);
        step();
        LD = 1'b0; START = 1'b0;
        step();
        step();
        CDN = 1'b0;
        #1;
        chk("rst_mid_tick", TICK, 1'b0);
        chk("rst_mid_busy", BUSY, 1'b0);
        chk("rst_mid_done", DONE, 1'b0);
        step();
        CDN = 1'b1;
        START = 1'b1;
        s = tcnt + 1;
        for (int i = 0; i < 5; i++) exp_q.push_back(s + i);
        step();
        START = 1'b0;
        chk("post_rst_busy", BUSY, 1'b1);
        repeat (4) step();
        STOP = 1'b1; step(); STOP = 1'b0;
        chk("q_f", exp_q.size() == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
